// File: rtl/apb_slave_mem_pkg.sv
// Shared types and constants for the APB slave memory.
// Imported by the bus interface, storage and top.
package apb_slave_mem_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   localparam int WAIT_W = 4;

   localparam logic [31:0] OOR_RDATA = 32'h0000_0000;

   // base is aligned to the window, so a hit is an upper-bit match
   function automatic logic in_window(
      input logic [31:0] addr,
      input logic [31:0] base,
      input int unsigned span_log2
   );
      return (addr >> span_log2) == (base >> span_log2);
   endfunction

endpackage

// File: rtl/apb_slave_mem_if.sv
// APB bus bundle between bridge and the memory slave.
// Master drives the request, slave returns data and ready.
interface apb_slave_mem_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [31:0]           paddr;
   logic [DATA_WIDTH-1:0] pwdata;
   logic [DATA_WIDTH-1:0] prdata;
   logic                  pready;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready
   );
endinterface

// File: rtl/apb_slave_regfile.sv
// Word storage: one synchronous write port, one combinational
// read port, cleared by the asynchronous reset.
module apb_slave_regfile #(
   parameter int DATA_WIDTH = 32,
   parameter int MEM_DEPTH  = 16,
   localparam int IDX_W     = $clog2(MEM_DEPTH)
) (
   input  logic                  pclk,
   input  logic                  reset,
   input  logic                  we,
   input  logic [IDX_W-1:0]      waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [IDX_W-1:0]      raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < MEM_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB slave with local word memory, programmable wait states,
// transfer counters and a sticky protocol-error flag.
module apb_slave_mem
   import apb_slave_mem_pkg::*;
#(
   parameter int          DATA_WIDTH = 32,
   parameter int          MEM_DEPTH  = 16,
   parameter logic [31:0] ADDR_BASE  = 32'h0000_0000
) (
   input  logic              pclk,
   input  logic              reset,
   apb_slave_mem_if.slave    bus,
   input  logic [WAIT_W-1:0] wait_cycles,
   output logic [15:0]       wr_count,
   output logic [15:0]       rd_count,
   output logic              proto_err
);

   localparam int IDX_W = $clog2(MEM_DEPTH);
   localparam int SPAN  = IDX_W + 2;

   state_t                state_q, state_d;
   logic [WAIT_W-1:0]     cnt_q, cnt_d;
   logic                  wr_q, wr_d;
   logic                  hit_q, hit_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
   logic [15:0]           wr_cnt_q, wr_cnt_d;
   logic [15:0]           rd_cnt_q, rd_cnt_d;
   logic                  perr_q, perr_d;

   logic                  setup;
   logic                  we;
   logic                  hit_in;
   logic [IDX_W-1:0]      idx_in;
   logic [DATA_WIDTH-1:0] rd_word;
   logic                  ready;

   assign idx_in = bus.paddr[IDX_W+1:2];
   assign hit_in = in_window(bus.paddr, ADDR_BASE, SPAN);
   assign ready  = (state_q == ACCESS) && (cnt_q == '0);

   apb_slave_regfile #(
      .DATA_WIDTH (DATA_WIDTH),
      .MEM_DEPTH  (MEM_DEPTH)
   ) u_regfile (
      .pclk  (pclk),
      .reset (reset),
      .we    (we),
      .waddr (idx_q),
      .wdata (wdata_q),
      .raddr (idx_in),
      .rdata (rd_word)
   );

   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         wr_q     <= 1'b0;
         hit_q    <= 1'b0;
         idx_q    <= '0;
         wdata_q  <= '0;
         prdata_q <= '0;
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
         perr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         wr_q     <= wr_d;
         hit_q    <= hit_d;
         idx_q    <= idx_d;
         wdata_q  <= wdata_d;
         prdata_q <= prdata_d;
         wr_cnt_q <= wr_cnt_d;
         rd_cnt_q <= rd_cnt_d;
         perr_q   <= perr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      wr_d     = wr_q;
      hit_d    = hit_q;
      idx_d    = idx_q;
      wdata_d  = wdata_q;
      prdata_d = prdata_q;
      wr_cnt_d = wr_cnt_q;
      rd_cnt_d = rd_cnt_q;
      perr_d   = perr_q;
      setup    = 1'b0;
      we       = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.psel && !bus.penable) begin
               setup = 1'b1;
            end else if (bus.psel && bus.penable) begin
               perr_d = 1'b1;
            end
         end
         ACCESS: begin
            if (!bus.psel) begin
               state_d = IDLE;
               perr_d  = 1'b1;
            end else if (!bus.penable) begin
               setup  = 1'b1;
               perr_d = 1'b1;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - WAIT_W'(1);
            end else begin
               state_d = IDLE;
               if (wr_q) begin
                  we       = hit_q;
                  wr_cnt_d = wr_cnt_q + 16'd1;
               end else begin
                  rd_cnt_d = rd_cnt_q + 16'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // a re-setup in ACCESS relatches exactly like one from IDLE
      if (setup) begin
         state_d  = ACCESS;
         cnt_d    = wait_cycles;
         wr_d     = bus.pwrite;
         hit_d    = hit_in;
         idx_d    = idx_in;
         wdata_d  = bus.pwdata;
         prdata_d = hit_in ? rd_word : DATA_WIDTH'(OOR_RDATA);
      end
   end

   assign bus.prdata = prdata_q;
   assign bus.pready = ready;
   assign wr_count   = wr_cnt_q;
   assign rd_count   = rd_cnt_q;
   assign proto_err  = perr_q;

endmodule
